// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: looks up each incoming 7-bit symbol in the Huffman
// code table and packs the variable-length codes MSB-first into OUT_W-bit
// words. The final word of a message is flagged with out_last and may be
// partial (or empty when the message carried no bits after the last word).
module huffman_bit_packer #(
    parameter int OUT_W  = 32,
    parameter int CODE_W = 128,
    parameter int LEN_W  = 7
) (
    input  logic                   clk,
    input  logic                   ctrl_reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_ascii,
    input  logic                   in_last,
    output logic [6:0]             lookup_ascii,
    input  logic [CODE_W-1:0]      lookup_code,
    input  logic [LEN_W-1:0]       lookup_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(OUT_W):0] out_bits,
    output logic                   out_last,
    output logic                   err_zero_len
);

    localparam int FILL_W = $clog2(OUT_W) + 1;
    localparam int SH_W   = $clog2(CODE_W) + 1;
    localparam int N_W    = (LEN_W > FILL_W) ? LEN_W : FILL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CODE_W-1:0]   code_r, code_s;
    logic [LEN_W-1:0]    rem_r, rem_s;
    logic [OUT_W-1:0]    word_r, word_s;
    logic [FILL_W-1:0]   fill_r, fill_s;
    logic                last_r, last_s;
    logic                out_valid_r, out_valid_s;
    logic [OUT_W-1:0]    out_data_r, out_data_s;
    logic [FILL_W-1:0]   out_bits_r, out_bits_s;
    logic                out_last_r, out_last_s;
    logic                err_r, err_s;

    // Packing datapath terms, used only while in PACK
    logic [N_W-1:0]      space_s;
    logic [N_W-1:0]      rem_ext_s;
    logic [N_W-1:0]      n_s;
    logic [OUT_W-1:0]    top_s;
    logic [OUT_W-1:0]    mask_s;
    logic [OUT_W-1:0]    pack_word_s;
    logic [CODE_W-1:0]   pack_code_s;
    logic [FILL_W-1:0]   pack_fill_s;
    logic [LEN_W-1:0]    pack_rem_s;
    logic [CODE_W-1:0]   load_code_s;

    assign lookup_ascii = in_ascii;
    assign in_ready     = (state_r == IDLE);
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_bits     = out_bits_r;
    assign out_last     = out_last_r;
    assign err_zero_len = err_r;

    // Left-align the looked-up code (a zero length shifts everything out) and
    // take n = min(rem, free bits) top bits of the code into the open word slot
    always_comb begin
        load_code_s = lookup_code << (SH_W'(CODE_W) - SH_W'(lookup_len));
        space_s     = N_W'(OUT_W) - N_W'(fill_r);
        rem_ext_s   = N_W'(rem_r);
        n_s         = (rem_ext_s < space_s) ? rem_ext_s : space_s;
        top_s       = code_r[CODE_W-1 -: OUT_W];
        mask_s      = ~({OUT_W{1'b1}} >> n_s);
        pack_word_s = word_r | ((top_s & mask_s) >> fill_r);
        pack_code_s = code_r << n_s;
        pack_fill_s = fill_r + FILL_W'(n_s);
        pack_rem_s  = rem_r - LEN_W'(n_s);
    end

    // Next-state and next-register values for the IDLE/PACK/EMIT controller
    always_comb begin
        state_s     = state_r;
        code_s      = code_r;
        rem_s       = rem_r;
        word_s      = word_r;
        fill_s      = fill_r;
        last_s      = last_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_bits_s  = out_bits_r;
        out_last_s  = out_last_r;
        err_s       = err_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    code_s  = load_code_s;
                    rem_s   = lookup_len;
                    last_s  = in_last;
                    state_s = PACK;
                    if (lookup_len == {LEN_W{1'b0}}) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PACK: begin
                word_s = pack_word_s;
                code_s = pack_code_s;
                fill_s = pack_fill_s;
                rem_s  = pack_rem_s;
                if (pack_fill_s == FILL_W'(OUT_W)) begin
                    state_s     = EMIT;
                    out_valid_s = 1'b1;
                    out_data_s  = pack_word_s;
                    out_bits_s  = pack_fill_s;
                    out_last_s  = last_r && (pack_rem_s == {LEN_W{1'b0}});
                end else if ((pack_rem_s == {LEN_W{1'b0}}) && last_r) begin
                    // Message ends inside this word (possibly an empty word)
                    state_s     = EMIT;
                    out_valid_s = 1'b1;
                    out_data_s  = pack_word_s;
                    out_bits_s  = pack_fill_s;
                    out_last_s  = 1'b1;
                end else if (pack_rem_s == {LEN_W{1'b0}}) begin
                    state_s = IDLE;
                end else begin
                    state_s = PACK;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    word_s      = {OUT_W{1'b0}};
                    fill_s      = {FILL_W{1'b0}};
                    out_valid_s = 1'b0;
                    out_data_s  = {OUT_W{1'b0}};
                    out_bits_s  = {FILL_W{1'b0}};
                    out_last_s  = 1'b0;
                    if (out_last_r) begin
                        last_s = 1'b0;
                    end else begin
                        last_s = last_r;
                    end
                    if (rem_r != {LEN_W{1'b0}}) begin
                        state_s = PACK;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered output state; reset drops any partial word
    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            code_r      <= {CODE_W{1'b0}};
            rem_r       <= {LEN_W{1'b0}};
            word_r      <= {OUT_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            last_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_bits_r  <= {FILL_W{1'b0}};
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            code_r      <= code_s;
            rem_r       <= rem_s;
            word_r      <= word_s;
            fill_r      <= fill_s;
            last_r      <= last_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_bits_r  <= out_bits_s;
            out_last_r  <= out_last_s;
            err_r       <= err_s;
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Testbench for huffman_bit_packer: directed scenarios with fixed expected
// words, then randomized messages checked against a bit-queue model. A
// monitor pops expected words whenever an output handshake occurs.
module tb_huffman_bit_packer;

    localparam int OUT_W  = 32;
    localparam int CODE_W = 128;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              ctrl_reset;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_ascii;
    logic              in_last;
    logic [6:0]        lookup_ascii;
    logic [CODE_W-1:0] lookup_code;
    logic [LEN_W-1:0]  lookup_len;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [5:0]        out_bits;
    logic              out_last;
    logic              err_zero_len;

    // Code table model, read combinationally
    logic [CODE_W-1:0] tbl_code [128];
    logic [LEN_W-1:0]  tbl_len  [128];

    typedef struct {
        logic [OUT_W-1:0] data;
        int               bits;
        bit               last;
    } word_t;

    word_t exp_q[$];
    bit    pend_q[$];
    int    checks  = 0;
    int    errors  = 0;
    bit    exp_err = 1'b0;
    int    rdy_mode = 1;   // 0 random, 1 always ready, 2 held low

    always #5 clk = ~clk;

    assign lookup_code = tbl_code[lookup_ascii];
    assign lookup_len  = tbl_len[lookup_ascii];

    huffman_bit_packer #(.OUT_W(OUT_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ascii(in_ascii), .in_last(in_last),
        .lookup_ascii(lookup_ascii), .lookup_code(lookup_code), .lookup_len(lookup_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last), .err_zero_len(err_zero_len)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [OUT_W-1:0] d, input int b, input bit l);
        word_t w;
        w.data = d;
        w.bits = b;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Reference: the message is a plain bit stream; a word leaves as soon as
    // OUT_W bits exist, and the message end flushes whatever is left unless
    // the last symbol itself closed a full word.
    function automatic void model_symbol(input logic [CODE_W-1:0] code, input int len, input bit last);
        word_t w;
        bit    closed_last;
        closed_last = 1'b0;
        if (len == 0) exp_err = 1'b1;
        for (int i = len - 1; i >= 0; i--) pend_q.push_back(code[i]);
        while (pend_q.size() >= OUT_W) begin
            w.data = '0;
            for (int b = OUT_W - 1; b >= 0; b--) w.data[b] = pend_q.pop_front();
            w.bits = OUT_W;
            w.last = last && (pend_q.size() == 0);
            if (w.last) closed_last = 1'b1;
            exp_q.push_back(w);
        end
        if (last && !closed_last) begin
            w.data = '0;
            w.bits = pend_q.size();
            for (int b = 0; b < w.bits; b++) w.data[OUT_W-1-b] = pend_q[b];
            w.last = 1'b1;
            exp_q.push_back(w);
            pend_q.delete();
        end
    endfunction

    task automatic send(input logic [6:0] a, input bit l, input bit use_model);
        int guard;
        guard    = 0;
        in_ascii = a;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && guard < 500) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            check("lookup_ascii", lookup_ascii, a);
            if (use_model) model_symbol(tbl_code[a], int'(tbl_len[a]), l);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("wait_valid", out_valid, 1);
    endtask

    // Output driver and monitor: decides out_ready for the next edge, checks
    // hold-stability under backpressure and pops expectations on handshakes
    initial begin
        bit               r;
        bit               stalled;
        logic [OUT_W-1:0] p_data;
        logic [5:0]       p_bits;
        logic             p_last;
        word_t            e;
        stalled   = 1'b0;
        out_ready = 1'b0;
        p_data = '0; p_bits = '0; p_last = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       r = ($urandom_range(0, 9) < 7);
                1:       r = 1'b1;
                default: r = 1'b0;
            endcase
            out_ready = r;
            if (out_valid && !ctrl_reset) begin
                check("in_ready_in_emit", in_ready, 0);
                if (stalled) begin
                    check("hold_data", out_data, p_data);
                    check("hold_bits", out_bits, p_bits);
                    check("hold_last", out_last, p_last);
                end
                if (r) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h bits %0d last %0d, none expected",
                                 out_data, out_bits, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.data);
                        check("word_bits", out_bits, e.bits);
                        check("word_last", out_last, e.last);
                    end
                end else begin
                    stalled = 1'b1;
                    p_data  = out_data;
                    p_bits  = out_bits;
                    p_last  = out_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Main stimulus sequence
    initial begin
        logic [OUT_W-1:0] held;
        for (int i = 0; i < 128; i++) begin
            tbl_code[i] = '0;
            tbl_len[i]  = '0;
        end
        in_valid   = 1'b0;
        in_ascii   = 7'd0;
        in_last    = 1'b0;
        ctrl_reset = 1'b1;
        repeat (3) tick();
        ctrl_reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bits", out_bits, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err_zero_len, 0);
        check("rst_in_ready", in_ready, 1);

        // Short codes into one partial word
        tbl_code[65] = 128'h5; tbl_len[65] = 7'd3;
        tbl_code[66] = 128'h1; tbl_len[66] = 7'd2;
        expect_word(32'hAD00_0000, 8, 1'b1);
        send(7'd65, 1'b0, 1'b0);
        send(7'd66, 1'b0, 1'b0);
        send(7'd65, 1'b1, 1'b0);
        wait_drain(100);

        // Exact fill, no trailing empty word
        tbl_code[1] = 128'h12; tbl_len[1] = 7'd8;
        tbl_code[2] = 128'h34; tbl_len[2] = 7'd8;
        tbl_code[3] = 128'h56; tbl_len[3] = 7'd8;
        tbl_code[4] = 128'h78; tbl_len[4] = 7'd8;
        expect_word(32'h1234_5678, 32, 1'b1);
        send(7'd1, 1'b0, 1'b0);
        send(7'd2, 1'b0, 1'b0);
        send(7'd3, 1'b0, 1'b0);
        send(7'd4, 1'b1, 1'b0);
        wait_drain(100);
        repeat (10) tick();

        // Code longer than a word
        tbl_code[5] = 128'hFF_FFFF_FFFF; tbl_len[5] = 7'd40;
        expect_word(32'hFFFF_FFFF, 32, 1'b0);
        expect_word(32'hFF00_0000, 8, 1'b1);
        send(7'd5, 1'b1, 1'b0);
        wait_drain(100);

        // Backpressure for 5 cycles
        rdy_mode = 2;
        expect_word(32'hA000_0000, 3, 1'b1);
        send(7'd65, 1'b1, 1'b0);
        wait_valid();
        held = out_data;
        check("bp_word", held, 32'hA000_0000);
        repeat (5) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_data", out_data, held);
        end
        check("bp_not_taken", exp_q.size(), 1);
        rdy_mode = 1;
        wait_drain(50);
        repeat (10) tick();

        // Zero-length symbol on an empty message, then stickiness
        tbl_code[0] = 128'hDEAD_BEEF; tbl_len[0] = 7'd0;
        expect_word(32'h0, 0, 1'b1);
        send(7'd0, 1'b1, 1'b0);
        wait_drain(50);
        check("err_set", err_zero_len, 1);
        expect_word(32'hA000_0000, 3, 1'b1);
        send(7'd65, 1'b1, 1'b0);
        wait_drain(50);
        check("err_sticky", err_zero_len, 1);

        // Reset during EMIT of the first word of a long code
        rdy_mode = 2;
        send(7'd5, 1'b1, 1'b0);
        wait_valid();
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_err", err_zero_len, 0);
        check("mid_rst_bits", out_bits, 0);
        rdy_mode = 1;
        expect_word(32'hA000_0000, 3, 1'b1);
        send(7'd65, 1'b1, 1'b0);
        wait_drain(50);

        // Randomized messages against the bit-stream model
        exp_err = 1'b0;
        pend_q.delete();
        for (int i = 0; i < 128; i++) begin
            tbl_code[i] = {$urandom, $urandom, $urandom, $urandom};
            tbl_len[i]  = ($urandom_range(0, 31) == 0) ? 7'd0 : 7'(($urandom_range(1, 70)));
        end
        rdy_mode = 0;
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(7'($urandom_range(0, 127)), ($urandom_range(0, 5) == 0) || (i == 249), 1'b1);
        end
        wait_drain(5000);
        check("rand_err", err_zero_len, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream consumer of the Huffman code table. Accepts a stream of 7-bit ASCII symbols and looks up each symbol's code and length through the table's combinational read port. Packs the variable-length codes MSB-first into fixed-width output words. Finishes with a final partial word marked `out_last`.

## Interface
Parameters:
- `OUT_W`, 32: output word width in bits (power of 2, ≤ 64).
- `CODE_W`, 128: width of the table code field.
- `LEN_W`, 7: width of the table length field.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `ctrl_reset` in 1: reset; synchronous, active-high.
- `in_valid` in 1: symbol present.
- `in_ready` out 1: block can accept a symbol this cycle.
- `in_ascii` in 7: symbol.
- `in_last` in 1: symbol is the final one of the message.
- `lookup_ascii` out 7: table read address, driven combinationally as `in_ascii`.
- `lookup_code` in CODE_W: code from table; valid bits are `[len-1:0]`, and bit `len-1` is sent first.
- `lookup_len` in LEN_W: code length, 0..127.
- `out_valid` out 1: output word present.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out OUT_W: packed word; first bit at `[OUT_W-1]`, unused low bits 0.
- `out_bits` out log2(OUT_W)+1: number of valid bits in `out_data`, 0..OUT_W.
- `out_last` out 1: word is the final word of the message.
- `err_zero_len` out 1: sticky; a symbol with `lookup_len==0` was accepted.

## Operation
- **State registers:**
  - `code_reg` (CODE_W): code left-aligned; the next bit to send is at the MSB.
  - `rem` (LEN_W): bits of the current code not yet packed.
  - `word` (OUT_W) and `fill`: the output word being built and its bit count.
  - `last_q`: the latched `in_last`.
- **FSM states:** IDLE, PACK, EMIT.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid`: latch `code_reg = lookup_code << (CODE_W-lookup_len)`, `rem=lookup_len`, `last_q=in_last`, then go to PACK.
  - If `lookup_len==0`, set `err_zero_len`; the symbol contributes no bits.
- **PACK:** `in_ready=0`. In one cycle:
  - Compute `n = min(rem, OUT_W-fill)`.
  - Place the top `n` bits of `code_reg` at `word[OUT_W-1-fill -: n]`.
  - Shift `code_reg` left by `n`; `fill += n`; `rem -= n`.
  - Next state, checked in order:
    - if `fill==OUT_W` → EMIT, with `out_last = last_q && rem==0`;
    - else if `rem==0 && last_q` → EMIT with `out_last=1`. This also covers `fill==0`: the bench sees a zero word with `out_bits=0`;
    - else if `rem==0` → IDLE, keeping `word` and `fill` for the next symbol.
- **EMIT:**
  - `out_valid=1`, with `out_data=word`, `out_bits=fill` and `out_last` held stable.
  - On `out_ready`: clear `word` and `fill`. If `rem>0` go to PACK; otherwise go to IDLE.
  - After an `out_last` word, `last_q` clears and the next message starts empty.
- `out_data`, `out_bits` and `out_last` are registered and change only on EMIT entry or exit.
- Codes longer than OUT_W span multiple words via PACK→EMIT→PACK.
- **Reset values:**
  - state=IDLE; `word`, `fill`, `rem`, `code_reg` and `last_q` = 0.
  - `out_valid=0`, `out_data=0`, `out_bits=0`, `out_last=0`.
  - `err_zero_len=0`; `in_ready=1` on the first cycle after reset.
  - Only `ctrl_reset` clears `err_zero_len`.

## Timing
- Symbol accepted at edge T → PACK during T+1.
- If the symbol does not complete a word, `in_ready=1` again at T+2. Throughput is 1 symbol per 2 cycles.
- Word completes in PACK at cycle T+1 → `out_valid=1` from T+2 and held until the `out_ready` handshake edge.
- After the handshake: continuation PACK in the next cycle, or IDLE (`in_ready=1`).
- **Backpressure:** `out_ready=0` freezes the block; `in_ready` stays 0 during PACK and EMIT.
- `ctrl_reset` asserted in any state, including mid-code or mid-EMIT: the next cycle shows reset values and the partial word is discarded.
- `lookup_ascii` follows `in_ascii` with zero latency. The table read is assumed combinational within the cycle.

## Test plan
- **Short codes into one partial word:** table A=3'b101, B=2'b01. Send A, B, A(last) → one word `out_data=0xAD000000`, `out_bits=8`, `out_last=1`.
- **Exact fill:** four 8-bit codes 0x12, 0x34, 0x56, 0x78, the last with `in_last` → a single word 0x12345678, `out_bits=32`, `out_last=1`, and no trailing empty word.
- **Code longer than a word:** 40-bit all-ones code, last → 0xFFFFFFFF with `out_bits=32`, `out_last=0`; then 0xFF000000 with `out_bits=8`, `out_last=1`.
- **Backpressure:** hold `out_ready=0` for 5 cycles while `out_valid=1` → `out_data`/`out_bits`/`out_last` stable and `in_ready=0` throughout; the word is accepted once on the `out_ready` edge.
- **Zero-length symbol:** `lookup_len=0` symbol with `in_last` on an empty message → `err_zero_len=1` (sticky), one word 0x00000000 with `out_bits=0`, `out_last=1`.
- **Reset mid-operation:** assert `ctrl_reset` during EMIT of the first word of a 40-bit code → next cycle `out_valid=0`, `in_ready=1`, `err_zero_len=0`. A following A(last) yields 0xA0000000 with `out_bits=3`.
